// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, serializer state encoding and the
// 3-bit bit-reversal used by both the core's input reorder and this unloader.
package fft_pkg;

    localparam int unsigned FFT_POINTS = 8;
    localparam int unsigned FFT_IDX_W  = 3;

    typedef logic [FFT_IDX_W-1:0] fft_idx_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } ser_state_e;

    function automatic fft_idx_t bitrev3(input fft_idx_t k);
        return {k[0], k[1], k[2]};
    endfunction

endpackage

// File: rtl/fft_out_serializer_if.sv
// Parallel frame input and per-bin output stream of the FFT unloader.
interface fft_out_serializer_if #(
    parameter int unsigned N = 16
);
    import fft_pkg::*;

    logic [FFT_POINTS*N-1:0] in_re;
    logic [FFT_POINTS*N-1:0] in_im;
    logic                    in_valid;
    logic                    in_ready;
    logic [N-1:0]            out_re;
    logic [N-1:0]            out_im;
    fft_idx_t                out_idx;
    logic                    out_valid;
    logic                    out_last;
    logic                    out_ready;

    // Producer/consumer side of the serializer.
    modport master (
        output in_re, in_im, in_valid, out_ready,
        input  in_ready, out_re, out_im, out_idx, out_valid, out_last
    );

    // Serializer side.
    modport slave (
        input  in_re, in_im, in_valid, out_ready,
        output in_ready, out_re, out_im, out_idx, out_valid, out_last
    );

endinterface

// File: rtl/fft_frame_buf.sv
// Eight-entry frame buffer with parallel load and a registered read port; a
// read of the index being loaded returns the incoming word in the same cycle.
module fft_frame_buf
    import fft_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [FFT_POINTS*W-1:0] wr_data,
    input  fft_idx_t                rd_idx,
    output logic [W-1:0]            rd_data
);

    logic [W-1:0] mem_q [FFT_POINTS];
    logic [W-1:0] mem_d [FFT_POINTS];
    logic [W-1:0] rd_data_q;
    logic [W-1:0] rd_data_d;

    always_comb begin
        mem_d = mem_q;
        if (load) begin
            for (int unsigned i = 0; i < FFT_POINTS; i++) begin
                mem_d[i] = wr_data[i*W +: W];
            end
        end
        rd_data_d = mem_d[rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FFT_POINTS; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_out_serializer.sv
// Captures one bit-reversed (or natural) 8-bin complex frame and streams it
// out in natural bin order, one bin per valid/ready beat.
module fft_out_serializer
    import fft_pkg::*;
#(
    parameter int unsigned N      = 16,
    parameter int unsigned BITREV = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_out_serializer_if.slave  bus
);

    localparam int unsigned W        = 2 * N;
    localparam fft_idx_t    LAST_IDX = FFT_IDX_W'(FFT_POINTS - 1);

    ser_state_e              state_q, state_d;
    fft_idx_t                idx_q, idx_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    load_c;
    logic                    beat_c;
    logic                    in_ready_c;
    logic [FFT_POINTS*W-1:0] bin_data_c;
    logic [W-1:0]            rd_data;

    // Route input slots into bin order; each entry packs {re, im}.
    always_comb begin
        fft_idx_t src;
        bin_data_c = '0;
        for (int unsigned b = 0; b < FFT_POINTS; b++) begin
            src = (BITREV != 0) ? bitrev3(FFT_IDX_W'(b)) : FFT_IDX_W'(b);
            bin_data_c[b*W +: W] = {bus.in_re[src*N +: N], bus.in_im[src*N +: N]};
        end
    end

    assign beat_c     = valid_q && bus.out_ready;
    assign in_ready_c = (state_q == ST_IDLE) || (beat_c && last_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        load_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    load_c  = 1'b1;
                    state_d = ST_STREAM;
                    idx_d   = '0;
                    valid_d = 1'b1;
                end
            end
            ST_STREAM: begin
                if (beat_c) begin
                    if (last_q) begin
                        idx_d = '0;
                        if (bus.in_valid) begin
                            load_c = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            valid_d = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + FFT_IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                valid_d = 1'b0;
            end
        endcase
        last_d = valid_d && (idx_d == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // Read index follows the next beat so read data lines up with out_idx.
    fft_frame_buf #(
        .W (W)
    ) u_frame_buf (
        .clk     (clk),
        .rst_n   (rst),
        .load    (load_c),
        .wr_data (bin_data_c),
        .rd_idx  (idx_d),
        .rd_data (rd_data)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.out_re    = rd_data[W-1:N];
    assign bus.out_im    = rd_data[N-1:0];
    assign bus.out_idx   = idx_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench for fft_out_serializer: one BITREV=1 and one BITREV=0 instance.
module tb_fft_out_serializer;
    import fft_pkg::*;

    localparam int unsigned N = 16;

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] re;
        logic [15:0] im;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [8*N-1:0] in_re, in_im;
    logic           in_valid_a, in_valid_b, out_ready;

    fft_out_serializer_if #(.N(N)) a_if ();
    fft_out_serializer_if #(.N(N)) b_if ();

    assign a_if.in_re     = in_re;
    assign a_if.in_im     = in_im;
    assign a_if.in_valid  = in_valid_a;
    assign a_if.out_ready = out_ready;
    assign b_if.in_re     = in_re;
    assign b_if.in_im     = in_im;
    assign b_if.in_valid  = in_valid_b;
    assign b_if.out_ready = out_ready;

    fft_out_serializer #(.N(N), .BITREV(1)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    fft_out_serializer #(.N(N), .BITREV(0)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    int n_pass = 0;
    int n_chk  = 0;

    logic [15:0] slot_re [8];
    logic [15:0] slot_im [8];
    logic [15:0] exp_re  [16];
    logic [15:0] exp_im  [16];
    beat_t       tab     [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int br(input int b);
        return ((b & 1) << 2) | (b & 2) | ((b >> 2) & 1);
    endfunction

    task automatic sample(input bit sel, output logic v, output logic last, output logic rdy,
                          output logic [2:0] idx, output logic [15:0] re, output logic [15:0] im);
        if (sel) begin
            v = b_if.out_valid; last = b_if.out_last; rdy = b_if.in_ready;
            idx = b_if.out_idx; re = b_if.out_re; im = b_if.out_im;
        end else begin
            v = a_if.out_valid; last = a_if.out_last; rdy = a_if.in_ready;
            idx = a_if.out_idx; re = a_if.out_re; im = a_if.out_im;
        end
    endtask

    // Pack slot arrays into the parallel bus and derive expected natural-order bins.
    task automatic load_frame(input bit bitrev, input int base,
                              output logic [8*N-1:0] pre, output logic [8*N-1:0] pim);
        pre = '0;
        pim = '0;
        for (int k = 0; k < 8; k++) begin
            pre[k*N +: N] = slot_re[k];
            pim[k*N +: N] = slot_im[k];
        end
        for (int b = 0; b < 8; b++) begin
            exp_re[base+b] = slot_re[bitrev ? br(b) : b];
            exp_im[base+b] = slot_im[bitrev ? br(b) : b];
        end
    endtask

    task automatic send(input bit sel, input string tag);
        logic v, last, rdy;
        logic [2:0] idx;
        logic [15:0] re, im;
        if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
        #1;
        sample(sel, v, last, rdy, idx, re, im);
        chk({tag, "_accept_ready"}, 32'(rdy), 32'd1);
        tick();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    // Drain one frame; mode 1 gives out_ready pattern 1,0,0,1,0,0,...
    task automatic collect(input bit sel, input int mode, input string tag);
        int beat = 0;
        int cyc  = 0;
        logic held = 1'b0;
        logic [15:0] hre, him;
        logic [2:0]  hidx;
        logic        hlast;
        logic v, last, rdy;
        logic [2:0] idx;
        logic [15:0] re, im;
        while (beat < 8 && cyc < 64) begin
            out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            #1;
            sample(sel, v, last, rdy, idx, re, im);
            chk({tag, "_valid"}, 32'(v), 32'd1);
            if (held) begin
                chk({tag, "_hold_re"}, 32'(re), 32'(hre));
                chk({tag, "_hold_im"}, 32'(im), 32'(him));
                chk({tag, "_hold_idx"}, 32'(idx), 32'(hidx));
                chk({tag, "_hold_last"}, 32'(last), 32'(hlast));
            end
            if (v && out_ready) begin
                chk({tag, "_idx"}, 32'(idx), 32'(beat));
                chk({tag, "_re"}, 32'(re), 32'(exp_re[beat]));
                chk({tag, "_im"}, 32'(im), 32'(exp_im[beat]));
                chk({tag, "_last"}, 32'(last), 32'(beat == 7));
                chk({tag, "_in_ready"}, 32'(rdy), 32'(beat == 7));
                beat++;
                held = 1'b0;
            end else if (v) begin
                chk({tag, "_stall_in_ready"}, 32'(rdy), 32'd0);
                held = 1'b1;
                hre = re; him = im; hidx = idx; hlast = last;
            end
            cyc++;
            tick();
        end
        chk({tag, "_beats"}, 32'(beat), 32'd8);
        out_ready = 1'b1;
        #1;
        sample(sel, v, last, rdy, idx, re, im);
        chk({tag, "_idle_after"}, 32'(v), 32'd0);
    endtask

    // Frame A, then frame B offered at beat offer_at of A; 16 beats expected without a bubble.
    task automatic run_two(input int offer_at, input string tag);
        logic [8*N-1:0] are, aim, bre, bim;
        logic v, last, rdy;
        logic [2:0] idx;
        logic [15:0] re, im;
        for (int k = 0; k < 8; k++) begin
            slot_re[k] = 16'(16'h0100 + k);
            slot_im[k] = 16'(16'h1100 + k);
        end
        load_frame(1'b1, 0, are, aim);
        for (int k = 0; k < 8; k++) begin
            slot_re[k] = 16'(16'h0200 + k);
            slot_im[k] = 16'(16'h2200 + k);
        end
        load_frame(1'b1, 8, bre, bim);
        in_re = are; in_im = aim; out_ready = 1'b1;
        send(1'b0, tag);
        in_re = bre; in_im = bim;
        in_valid_a = (offer_at == 0);
        for (int i = 0; i < 16; i++) begin
            if (i == offer_at) in_valid_a = 1'b1;
            #1;
            sample(1'b0, v, last, rdy, idx, re, im);
            chk({tag, "_valid"}, 32'(v), 32'd1);
            chk({tag, "_idx"}, 32'(idx), 32'(i % 8));
            chk({tag, "_re"}, 32'(re), 32'(exp_re[i]));
            chk({tag, "_im"}, 32'(im), 32'(exp_im[i]));
            chk({tag, "_last"}, 32'(last), 32'(i % 8 == 7));
            chk({tag, "_in_ready"}, 32'(rdy), 32'(i % 8 == 7));
            tick();
            if (i == 7) in_valid_a = 1'b0;
        end
        #1;
        chk({tag, "_idle_after"}, 32'(a_if.out_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        logic [8*N-1:0] pre, pim;
        rst = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0; out_ready = 1'b0;
        in_re = '0; in_im = '0;

        tab[0] = '{3'd0, 16'd1, 16'hFFFF, 1'b0};
        tab[1] = '{3'd1, 16'd5, 16'hFFFB, 1'b0};
        tab[2] = '{3'd2, 16'd3, 16'hFFFD, 1'b0};
        tab[3] = '{3'd3, 16'd7, 16'hFFF9, 1'b0};
        tab[4] = '{3'd4, 16'd2, 16'hFFFE, 1'b0};
        tab[5] = '{3'd5, 16'd6, 16'hFFFA, 1'b0};
        tab[6] = '{3'd6, 16'd4, 16'hFFFC, 1'b0};
        tab[7] = '{3'd7, 16'd8, 16'hFFF8, 1'b1};

        // Reset state
        #12;
        chk("rst_out_valid", 32'(a_if.out_valid), 32'd0);
        chk("rst_out_last", 32'(a_if.out_last), 32'd0);
        chk("rst_out_idx", 32'(a_if.out_idx), 32'd0);
        chk("rst_out_re", 32'(a_if.out_re), 32'd0);
        chk("rst_out_im", 32'(a_if.out_im), 32'd0);
        chk("rst_in_ready_a", 32'(a_if.in_ready), 32'd1);
        chk("rst_in_ready_b", 32'(b_if.in_ready), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(a_if.in_ready), 32'd1);

        // Single frame, BITREV=1, table-driven
        for (int k = 0; k < 8; k++) begin
            slot_re[k] = 16'(k + 1);
            slot_im[k] = 16'(-(k + 1));
        end
        load_frame(1'b1, 0, pre, pim);
        in_re = pre; in_im = pim; out_ready = 1'b1;
        send(1'b0, "t1");
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t1_valid", 32'(a_if.out_valid), 32'd1);
            chk("t1_idx", 32'(a_if.out_idx), 32'(tab[i].idx));
            chk("t1_re", 32'(a_if.out_re), 32'(tab[i].re));
            chk("t1_im", 32'(a_if.out_im), 32'(tab[i].im));
            chk("t1_last", 32'(a_if.out_last), 32'(tab[i].last));
            chk("t1_in_ready", 32'(a_if.in_ready), 32'(i == 7));
            tick();
        end
        #1;
        chk("t1_idle_after", 32'(a_if.out_valid), 32'd0);

        // Backpressure, same frame
        for (int i = 0; i < 8; i++) begin
            exp_re[i] = tab[i].re;
            exp_im[i] = tab[i].im;
        end
        send(1'b0, "bp");
        collect(1'b0, 1, "bp");

        // Back-to-back frames and a frame offered while busy
        run_two(0, "b2b");
        run_two(4, "busy");

        // BITREV=0 with extreme values
        for (int k = 0; k < 8; k++) begin
            slot_re[k] = (k % 2 == 0) ? 16'h7FFF : 16'h8000;
            slot_im[k] = (k % 2 == 0) ? 16'h8000 : 16'h7FFF;
        end
        slot_re[5] = 16'h0001;
        load_frame(1'b0, 0, pre, pim);
        in_re = pre; in_im = pim;
        send(1'b1, "nat");
        collect(1'b1, 1, "nat");

        // Reset mid-stream after three beats
        for (int k = 0; k < 8; k++) begin
            slot_re[k] = 16'(k + 1);
            slot_im[k] = 16'(-(k + 1));
        end
        load_frame(1'b1, 0, pre, pim);
        in_re = pre; in_im = pim; out_ready = 1'b1;
        send(1'b0, "mrst");
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mrst_pre_idx", 32'(a_if.out_idx), 32'(i));
            tick();
        end
        rst = 1'b0;
        #1;
        chk("mrst_valid", 32'(a_if.out_valid), 32'd0);
        chk("mrst_idx", 32'(a_if.out_idx), 32'd0);
        chk("mrst_re", 32'(a_if.out_re), 32'd0);
        chk("mrst_im", 32'(a_if.out_im), 32'd0);
        chk("mrst_last", 32'(a_if.out_last), 32'd0);
        chk("mrst_in_ready", 32'(a_if.in_ready), 32'd1);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst_no_resume", 32'(a_if.out_valid), 32'd0);
            chk("mrst_ready_after", 32'(a_if.in_ready), 32'd1);
        end
        send(1'b0, "mrst_next");
        collect(1'b0, 0, "mrst_next");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_out_serializer.md
# fft_out_serializer

Output unloader for the 8-point FFT core. It captures one complete frame of eight complex results, presented in parallel in bit-reversed bin order, on a valid/ready handshake. It then streams them out one bin per beat in natural order (bin 0..7) over a valid/ready stream interface with an index and last flag. It sits between the FFT butterfly pipeline output registers and any downstream consumer.

## Interface
- `N`, default 16: width of each real/imag component, two's complement.
- `BITREV`, default 1: 1 means input slot k holds bin bitrev3(k); 0 means input slot k holds bin k.
- `clk`, in, 1: the block's single clock; all state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `in_re`, in, 8*N: real parts; slot k is `in_re[k*N +: N]`.
- `in_im`, in, 8*N: imaginary parts, same packing as `in_re`.
- `in_valid`, in, 1: a frame is present on `in_re`/`in_im`.
- `in_ready`, out, 1: the block can accept a frame this cycle.
- `out_re`, out, N: real part of the current bin.
- `out_im`, out, N: imaginary part of the current bin.
- `out_idx`, out, 3: natural-order bin number of the current beat.
- `out_valid`, out, 1: the output beat is valid.
- `out_last`, out, 1: asserted together with `out_idx`==7.
- `out_ready`, in, 1: downstream accepts the beat.

## Operation
- **States:**
  - IDLE: buffer empty, `out_valid`=0.
  - STREAM: frame held, `out_valid`=1.
- **Frame accept.** A frame is accepted when `in_valid`&&`in_ready`. All 16 components are latched into the frame buffer, bin-indexed per `BITREV`, and the state goes to STREAM with `out_idx`=0.
- **`in_ready` (combinational):**
  - 1 in IDLE.
  - In STREAM, 1 only when the final beat completes this cycle (`out_valid`&&`out_ready`&&`out_last`). This allows back-to-back frames without a bubble.
- **Beat transfer.** A beat transfers when `out_valid`&&`out_ready`.
  - On transfer with `out_idx`<7: `out_idx` increments.
  - On transfer with `out_idx`==7: the block returns to IDLE, or, if a new frame is accepted the same cycle, stays in STREAM with `out_idx`=0 and new data.
- **Output stability.** While `out_valid`&&!`out_ready`, `out_re`, `out_im`, `out_idx` and `out_last` hold stable.
- **Data integrity.** No arithmetic is performed; data passes bit-exact.
- **Upstream contract.** The upstream holds `in_valid` and its data until `in_ready`. The block never drops or overwrites a frame in flight.
- **Reset mid-stream.** The frame in progress is discarded; no partial-frame completion after release.

## Timing
- **Reset values:** `out_valid`=0, `out_last`=0, `out_idx`=0, `out_re`=0, `out_im`=0, state IDLE. Hence `in_ready`=1 while reset is low and after release.
- **Latency:** the frame is accepted at edge t; bin 0 is valid from t+1. With `out_ready` held high, bins 0..7 appear at t+1..t+8 and `out_last` at t+8.
- **Throughput:** with continuous `in_valid` and `out_ready`, a new frame is accepted at t+8 and its bin 0 appears at t+9. That is 8 beats per frame, no idle cycles.
- **Output registering:** `out_re`, `out_im`, `out_idx`, `out_valid` and `out_last` are registered. No combinational path from `out_ready` or `in_valid` to any of them.
- **Combinational paths:** `in_ready` depends combinationally on `out_ready`. This is the only combinational input-to-output path.
- **Simultaneous events:** `in_valid` during STREAM before the last beat is ignored; `in_ready`=0 and the state is unchanged.

## Structure
- **Shared package `fft_pkg`:**
  - `FFT_POINTS`=8
  - `FFT_IDX_W`=3
  - `bitrev3` function, shared with the FFT core's input reorder.
- **Sub-module `fft_frame_buf`:**
  - 8 entries of 2*N bits, async active-low reset to 0.
  - Parallel load enable, 3-bit read index, registered read data.
- **Top level:** the top contains the FSM, index counter and handshake logic.

## Test plan
- **Single frame, BITREV=1.**
  - Stimulus: slot k re=k+1, im=-(k+1), `out_ready`=1.
  - Required: beats at t+1..t+8 carry re = bitrev3(idx)+1, i.e. 1,5,3,7,2,6,4,8; im is the negation; `out_last` only on beat 8.
- **Backpressure.**
  - Stimulus: `out_ready` toggles 1,0,0,1,...
  - Required: data and `out_idx` are held during stalls, and the sequence is identical to the unstalled case; `in_ready`=0 throughout.
- **Back-to-back frames.**
  - Stimulus: frames A (re=0x0100+k) and B (re=0x0200+k) with `in_valid` continuous.
  - Required: 16 consecutive valid beats, with B accepted in the same cycle as A's last beat and no bubble.
- **BITREV=0 with extreme values.**
  - Stimulus: N=16, re=0x7FFF/0x8000 alternating.
  - Required: natural order, bit-exact passthrough.
- **Reset mid-stream.**
  - Stimulus: assert `rst` low after beat 3.
  - Required: `out_valid`=0 and all outputs 0 immediately (asynchronously); `in_ready`=1 after release; the next frame starts at `out_idx`=0.
- **`in_valid` while busy.**
  - Stimulus: a new frame is offered at beat 4.
  - Required: not accepted until the last beat completes; the current frame data is unaltered.
